// File: rtl/fp32_mul_seq.sv
// Sequential binary32 multiplier: decodes operands and resolves special cases locally,
// delegates the 24x24 significand product to an external multiplier, then normalises and rounds.
module fp32_mul_seq #(
    parameter int unsigned mul_len = 24,
    parameter int unsigned out_len = 48
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        in_a,
    input  logic [31:0]        in_b,
    output logic               mac_start,
    output logic [mul_len-1:0] mac_a,
    output logic [mul_len-1:0] mac_b,
    input  logic [out_len-1:0] mac_product,
    input  logic               mac_done,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        out_result,
    output logic [3:0]         out_flags
);
    typedef enum logic [2:0] {IDLE, START, WAIT, NORM, OUT} state_t;

    state_t             state;
    logic               sign_q;
    logic [7:0]         ea_q;
    logic [7:0]         eb_q;
    logic [out_len-1:0] prod_q;

    logic [7:0]  ea, eb;
    logic [22:0] fa, fb;
    logic        sign_in;
    logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic        special;
    logic [31:0] sp_result;
    logic [3:0]  sp_flags;

    assign ea      = in_a[30:23];
    assign eb      = in_b[30:23];
    assign fa      = in_a[22:0];
    assign fb      = in_b[22:0];
    assign sign_in = in_a[31] ^ in_b[31];

    // Denormal inputs (exp == 0) are folded into zero before classification.
    always_comb begin
        a_zero    = (ea == 8'h00);
        b_zero    = (eb == 8'h00);
        a_inf     = (ea == 8'hFF) && (fa == '0);
        b_inf     = (eb == 8'hFF) && (fb == '0);
        a_nan     = (ea == 8'hFF) && (fa != '0);
        b_nan     = (eb == 8'hFF) && (fb != '0);
        special   = a_nan | b_nan | a_inf | b_inf | a_zero | b_zero;
        sp_result = {sign_in, 31'd0};
        sp_flags  = '0;
        if (a_nan | b_nan | (a_inf & b_zero) | (b_inf & a_zero)) begin
            sp_result = 32'h7FC0_0000;
            sp_flags  = 4'b1000;
        end else if (a_inf | b_inf) begin
            sp_result = {sign_in, 8'hFF, 23'd0};
        end
    end

    logic [47:0]       p;
    logic signed [9:0] e_base, e_norm, e_fin;
    logic [22:0]       mant;
    logic              g, s, inc, inexact;
    logic [23:0]       mant_r;
    logic [31:0]       nm_result;
    logic [3:0]        nm_flags;

    assign p = prod_q;

    always_comb begin
        e_base = $signed({2'b00, ea_q}) + $signed({2'b00, eb_q}) - 10'sd127;
        if (p[47]) begin
            mant   = p[46:24];
            g      = p[23];
            s      = |p[22:0];
            e_norm = e_base + 10'sd1;
        end else begin
            mant   = p[45:23];
            g      = p[22];
            s      = |p[21:0];
            e_norm = e_base;
        end
        inc     = g & (s | mant[0]);
        mant_r  = {1'b0, mant} + {23'd0, inc};
        // A carry out leaves mant_r[22:0] at zero, which is the correct renormalised fraction.
        e_fin   = mant_r[23] ? e_norm + 10'sd1 : e_norm;
        inexact = g | s;
        if (e_fin >= 10'sd255) begin
            nm_result = {sign_q, 8'hFF, 23'd0};
            nm_flags  = 4'b0101;
        end else if (e_fin <= 10'sd0) begin
            nm_result = {sign_q, 31'd0};
            nm_flags  = 4'b0011;
        end else begin
            nm_result = {sign_q, e_fin[7:0], mant_r[22:0]};
            nm_flags  = {3'b000, inexact};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            in_ready   <= 1'b1;
            mac_start  <= 1'b0;
            mac_a      <= '0;
            mac_b      <= '0;
            out_valid  <= 1'b0;
            out_result <= '0;
            out_flags  <= '0;
            sign_q     <= 1'b0;
            ea_q       <= '0;
            eb_q       <= '0;
            prod_q     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        in_ready <= 1'b0;
                        sign_q   <= sign_in;
                        ea_q     <= ea;
                        eb_q     <= eb;
                        if (special) begin
                            out_result <= sp_result;
                            out_flags  <= sp_flags;
                            out_valid  <= 1'b1;
                            state      <= OUT;
                        end else begin
                            mac_a     <= mul_len'({1'b1, fa});
                            mac_b     <= mul_len'({1'b1, fb});
                            mac_start <= 1'b1;
                            state     <= START;
                        end
                    end
                end
                START: begin
                    mac_start <= 1'b0;
                    state     <= WAIT;
                end
                WAIT: begin
                    if (mac_done) begin
                        prod_q <= mac_product;
                        state  <= NORM;
                    end
                end
                NORM: begin
                    out_result <= nm_result;
                    out_flags  <= nm_flags;
                    out_valid  <= 1'b1;
                    state      <= OUT;
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fp32_mul_seq.sv
// Directed bench for fp32_mul_seq; the bench plays the external significand multiplier.
module tb_fp32_mul_seq;
    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        mac_start;
    logic [23:0] mac_a;
    logic [23:0] mac_b;
    logic [47:0] mac_product;
    logic        mac_done;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [3:0]  out_flags;

    int errors = 0;
    int checks = 0;
    int starts = 0;

    fp32_mul_seq #(.mul_len(24), .out_len(48)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .mac_start  (mac_start),
        .mac_a      (mac_a),
        .mac_b      (mac_b),
        .mac_product(mac_product),
        .mac_done   (mac_done),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_flags  (out_flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (mac_start === 1'b1) starts++;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one operation end to end and reports what was observed; callers do the comparing.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [47:0] prod,
                          output logic started, output logic [23:0] ma, output logic [23:0] mb,
                          output logic stable, output int lat, output logic [31:0] res,
                          output logic [3:0] fl, output logic timeout);
        int n;
        timeout = 1'b0;
        started = 1'b0;
        stable  = 1'b1;
        ma      = '0;
        mb      = '0;
        lat     = 0;
        in_a     = a;
        in_b     = b;
        in_valid = 1'b1;
        n = 0;
        while (in_ready !== 1'b1 && n < 20) begin tick(); n++; end
        if (in_ready !== 1'b1) timeout = 1'b1;
        tick();
        in_valid = 1'b0;
        if (mac_start === 1'b1) begin
            started = 1'b1;
            ma = mac_a;
            mb = mac_b;
            for (int i = 0; i < 3; i++) begin
                tick();
                if (mac_a !== ma || mac_b !== mb) stable = 1'b0;
            end
            mac_product = prod;
            mac_done    = 1'b1;
            while (out_valid !== 1'b1 && lat < 10) begin
                tick();
                lat++;
                mac_done = 1'b0;
            end
            mac_done = 1'b0;
        end else begin
            lat = 1;
            while (out_valid !== 1'b1 && lat < 10) begin tick(); lat++; end
        end
        if (out_valid !== 1'b1) timeout = 1'b1;
        res = out_result;
        fl  = out_flags;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (mac_start !== 1'b0) begin errors++; $display("FAIL reset_mac_start: got %b expected 0", mac_start); end
        checks++; if (mac_a !== 24'h0 || mac_b !== 24'h0) begin errors++; $display("FAIL reset_mac_ab: got %h/%h expected 0/0", mac_a, mac_b); end
        checks++; if (out_result !== 32'h0) begin errors++; $display("FAIL reset_out_result: got %h expected 00000000", out_result); end
        checks++; if (out_flags !== 4'h0) begin errors++; $display("FAIL reset_out_flags: got %b expected 0000", out_flags); end
        rst = 1'b0;
        tick();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready: got %b expected 1", in_ready); end
    endtask

    task automatic test_normal();
        logic st, stb, to;
        logic [23:0] ma, mb;
        logic [31:0] res;
        logic [3:0] fl;
        int lat, s0;
        s0 = starts;
        run_op(32'h4000_0000, 32'h4040_0000, 48'h6000_0000_0000, st, ma, mb, stb, lat, res, fl, to);
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL normal_timeout: got %b expected 0", to); end
        checks++; if (st !== 1'b1) begin errors++; $display("FAIL normal_started: got %b expected 1", st); end
        checks++; if (ma !== 24'h80_0000 || mb !== 24'hC0_0000) begin errors++; $display("FAIL normal_mac_ab: got %h/%h expected 800000/c00000", ma, mb); end
        checks++; if (stb !== 1'b1) begin errors++; $display("FAIL normal_mac_stable: got %b expected 1", stb); end
        checks++; if (lat != 2) begin errors++; $display("FAIL normal_latency: got %0d expected 2", lat); end
        checks++; if (res !== 32'h40C0_0000) begin errors++; $display("FAIL normal_result: got %h expected 40c00000", res); end
        checks++; if (fl !== 4'b0000) begin errors++; $display("FAIL normal_flags: got %b expected 0000", fl); end
        checks++; if (starts - s0 != 1) begin errors++; $display("FAIL normal_start_count: got %0d expected 1", starts - s0); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL normal_ready_after: got %b expected 1", in_ready); end
        // Negative operand, same magnitudes.
        run_op(32'hC000_0000, 32'h4040_0000, 48'h6000_0000_0000, st, ma, mb, stb, lat, res, fl, to);
        checks++; if (res !== 32'hC0C0_0000 || fl !== 4'b0000) begin errors++; $display("FAIL signed_result: got %h/%b expected c0c00000/0000", res, fl); end
    endtask

    task automatic test_rounding();
        logic st, stb, to;
        logic [23:0] ma, mb;
        logic [31:0] res;
        logic [3:0] fl;
        int lat;
        // (2^23+1)^2 = 2^46 + 2^24 + 1: sticky only, no increment.
        run_op(32'h3F80_0001, 32'h3F80_0001, 48'h4000_0100_0001, st, ma, mb, stb, lat, res, fl, to);
        checks++; if (ma !== 24'h80_0001) begin errors++; $display("FAIL round_mac_a: got %h expected 800001", ma); end
        checks++; if (res !== 32'h3F80_0002 || fl !== 4'b0001) begin errors++; $display("FAIL round_sticky: got %h/%b expected 3f800002/0001", res, fl); end
        // Tie with odd mantissa: rounds up and carries out into the exponent.
        run_op(32'h3F80_0000, 32'h3F80_0000, 48'hFFFF_FF80_0000, st, ma, mb, stb, lat, res, fl, to);
        checks++; if (res !== 32'h4080_0000 || fl !== 4'b0001) begin errors++; $display("FAIL round_carry: got %h/%b expected 40800000/0001", res, fl); end
        // Tie with even mantissa: stays.
        run_op(32'h3F80_0000, 32'h3F80_0000, 48'h8000_0080_0000, st, ma, mb, stb, lat, res, fl, to);
        checks++; if (res !== 32'h4000_0000 || fl !== 4'b0001) begin errors++; $display("FAIL round_tie_even: got %h/%b expected 40000000/0001", res, fl); end
        // Above half with even mantissa: rounds up.
        run_op(32'h3F80_0000, 32'h3F80_0000, 48'h8000_0080_0001, st, ma, mb, stb, lat, res, fl, to);
        checks++; if (res !== 32'h4000_0001 || fl !== 4'b0001) begin errors++; $display("FAIL round_up: got %h/%b expected 40000001/0001", res, fl); end
    endtask

    task automatic test_specials();
        logic st, stb, to;
        logic [23:0] ma, mb;
        logic [31:0] res;
        logic [3:0] fl;
        int lat, s0;
        s0 = starts;
        run_op(32'h7F80_0000, 32'h0000_0000, 48'h0, st, ma, mb, stb, lat, res, fl, to);
        checks++; if (res !== 32'h7FC0_0000 || fl !== 4'b1000) begin errors++; $display("FAIL inf_x_zero: got %h/%b expected 7fc00000/1000", res, fl); end
        checks++; if (lat != 1) begin errors++; $display("FAIL special_latency: got %0d expected 1", lat); end
        run_op(32'h8000_0000, 32'h3F80_0000, 48'h0, st, ma, mb, stb, lat, res, fl, to);
        checks++; if (res !== 32'h8000_0000 || fl !== 4'b0000) begin errors++; $display("FAIL negzero_x_one: got %h/%b expected 80000000/0000", res, fl); end
        run_op(32'h3F80_0000, 32'h7FA0_0000, 48'h0, st, ma, mb, stb, lat, res, fl, to);
        checks++; if (res !== 32'h7FC0_0000 || fl !== 4'b1000) begin errors++; $display("FAIL nan_input: got %h/%b expected 7fc00000/1000", res, fl); end
        run_op(32'h7F80_0000, 32'hC000_0000, 48'h0, st, ma, mb, stb, lat, res, fl, to);
        checks++; if (res !== 32'hFF80_0000 || fl !== 4'b0000) begin errors++; $display("FAIL inf_x_neg: got %h/%b expected ff800000/0000", res, fl); end
        run_op(32'h0000_0001, 32'h7F80_0000, 48'h0, st, ma, mb, stb, lat, res, fl, to);
        checks++; if (res !== 32'h7FC0_0000 || fl !== 4'b1000) begin errors++; $display("FAIL daz_x_inf: got %h/%b expected 7fc00000/1000", res, fl); end
        checks++; if (starts - s0 != 0) begin errors++; $display("FAIL special_no_start: got %0d expected 0", starts - s0); end
    endtask

    task automatic test_ovf_unf();
        logic st, stb, to;
        logic [23:0] ma, mb;
        logic [31:0] res;
        logic [3:0] fl;
        int lat;
        run_op(32'h7F00_0000, 32'h7F00_0000, 48'h4000_0000_0000, st, ma, mb, stb, lat, res, fl, to);
        checks++; if (res !== 32'h7F80_0000 || fl !== 4'b0101) begin errors++; $display("FAIL overflow: got %h/%b expected 7f800000/0101", res, fl); end
        run_op(32'h0080_0000, 32'h8080_0000, 48'h4000_0000_0000, st, ma, mb, stb, lat, res, fl, to);
        checks++; if (res !== 32'h8000_0000 || fl !== 4'b0011) begin errors++; $display("FAIL underflow: got %h/%b expected 80000000/0011", res, fl); end
    endtask

    task automatic test_backpressure();
        int n;
        in_a = 32'h7F80_0000;
        in_b = 32'hC000_0000;
        in_valid = 1'b1;
        n = 0;
        while (in_ready !== 1'b1 && n < 20) begin tick(); n++; end
        tick();
        // Keep a second request pending for the whole stall.
        in_a = 32'h4000_0000;
        in_b = 32'h4040_0000;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_result !== 32'hFF80_0000 || out_flags !== 4'b0000 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold[%0d]: got v=%b r=%h f=%b rdy=%b expected v=1 r=ff800000 f=0000 rdy=0",
                         i, out_valid, out_result, out_flags, in_ready);
            end
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || mac_start !== 1'b0) begin
            errors++; $display("FAIL handshake_cycle: got v=%b rdy=%b start=%b expected 0/1/0", out_valid, in_ready, mac_start); end
        tick();
        in_valid = 1'b0;
        checks++; if (mac_start !== 1'b1 || in_ready !== 1'b0) begin
            errors++; $display("FAIL resume_accept: got start=%b rdy=%b expected 1/0", mac_start, in_ready); end
        tick();
        tick();
        mac_product = 48'h6000_0000_0000;
        mac_done = 1'b1;
        tick();
        mac_done = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b1 || out_result !== 32'h40C0_0000) begin
            errors++; $display("FAIL resume_result: got v=%b r=%h expected 1/40c00000", out_valid, out_result); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset_in_wait();
        logic st, stb, to;
        logic [23:0] ma, mb;
        logic [31:0] res;
        logic [3:0] fl;
        int lat, n;
        in_a = 32'h4000_0000;
        in_b = 32'h4040_0000;
        in_valid = 1'b1;
        n = 0;
        while (in_ready !== 1'b1 && n < 20) begin tick(); n++; end
        tick();
        in_valid = 1'b0;
        tick();
        #2 rst = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1 || mac_a !== 24'h0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL async_reset: got rdy=%b mac_a=%h v=%b expected 1/000000/0", in_ready, mac_a, out_valid); end
        #1 rst = 1'b0;
        tick();
        mac_product = 48'h6000_0000_0000;
        mac_done = 1'b1;
        tick();
        mac_done = 1'b0;
        tick();
        tick();
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL late_mac_done: got v=%b rdy=%b expected 0/1", out_valid, in_ready); end
        run_op(32'h4040_0000, 32'h4040_0000, 48'h9000_0000_0000, st, ma, mb, stb, lat, res, fl, to);
        checks++; if (res !== 32'h4110_0000 || fl !== 4'b0000 || to !== 1'b0) begin
            errors++; $display("FAIL after_reset_op: got %h/%b to=%b expected 41100000/0000 to=0", res, fl, to); end
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in_a = '0;
        in_b = '0;
        mac_product = '0;
        mac_done = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_normal();
        test_rounding();
        test_specials();
        test_ovf_unf();
        test_backpressure();
        test_reset_in_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
